// File: rtl/bitblade_pkg.sv
// Shared encodings, widths and types for the BitBlade shift-accumulate slice.
// BITBLADE_ACC_SAT_EN selects a saturating accumulator with an acc_sat flag.
package bitblade_pkg;

    localparam logic [1:0] PREC_2B = 2'd0;
    localparam logic [1:0] PREC_4B = 2'd1;
    localparam logic [1:0] PREC_8B = 2'd2;

    localparam int PP_W    = 6;
    localparam int PSUM_W  = 22;
    localparam int N_BRICK = 16;

    typedef logic signed [PSUM_W-1:0] psum_t;

    typedef struct packed {
        logic  valid;
        logic  last;
        psum_t psum;
    } s1_t;

    // Bit weight of a 2b chunk at position idx inside an operand of precision prec.
    function automatic logic [3:0] chunk_shift(input logic [1:0] prec,
                                               input logic [1:0] idx);
        logic [3:0] sh;
        unique case (1'b1)
            (prec == PREC_2B):                  sh = 4'd0;
            (prec == PREC_4B):                  sh = {2'b00, idx[0], 1'b0};
            (prec == PREC_8B), (prec == 2'b11): sh = {1'b0, idx, 1'b0};
            default:                            sh = 4'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/bitblade_shift_tree.sv
// Combinational shift of 16 BitBrick products by chunk weight
// followed by a balanced 16:1 adder tree producing the 22b partial sum.
module bitblade_shift_tree
    import bitblade_pkg::*;
(
    input  logic [N_BRICK*PP_W-1:0] pp_flat,
    input  logic [1:0]              prec_x,
    input  logic [1:0]              prec_y,
    output psum_t                   psum
);

    psum_t term [N_BRICK];
    psum_t l1   [8];
    psum_t l2   [4];
    psum_t l3   [2];

    always_comb begin
        logic [3:0] sh;
        for (int k = 0; k < N_BRICK; k++) begin
            sh      = chunk_shift(prec_x, 2'(k / 4))
                    + chunk_shift(prec_y, 2'(k % 4));
            term[k] = psum_t'($signed(pp_flat[k*PP_W +: PP_W])) <<< sh;
        end
        for (int k = 0; k < 8; k++) l1[k] = term[2*k] + term[2*k+1];
        for (int k = 0; k < 4; k++) l2[k] = l1[2*k] + l1[2*k+1];
        for (int k = 0; k < 2; k++) l3[k] = l2[2*k] + l2[2*k+1];
        psum = l3[0] + l3[1];
    end

endmodule

// File: rtl/bitblade_shift_accum.sv
// BitBlade PE back end: registered partial sum, accumulator and result handshake.
// Define BITBLADE_ACC_SAT_EN for a saturating accumulator and the acc_sat output.
module bitblade_shift_accum
    import bitblade_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_BRICK*PP_W-1:0] pp_flat,
    input  logic [1:0]              prec_x,
    input  logic [1:0]              prec_y,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef BITBLADE_ACC_SAT_EN
    ,
    output logic                    acc_sat
`endif
);

    psum_t                   psum_w;
    psum_t                   s1_psum;
    s1_t                     s1_q, s1_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic signed [ACC_W-1:0] acc_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    ov_q, ov_d;
    logic                    stall;
    logic                    adv;

    bitblade_shift_tree u_tree (
        .pp_flat (pp_flat),
        .prec_x  (prec_x),
        .prec_y  (prec_y),
        .psum    (psum_w)
    );

    // Only a finished result waiting on a busy consumer can block stage 1.
    assign stall    = s1_q.valid & s1_q.last & ov_q & ~out_ready;
    assign in_ready = ~s1_q.valid | ~stall;
    assign adv      = s1_q.valid & ~stall;

    assign s1_psum  = s1_q.psum;
    assign acc_ext  = ACC_W'(s1_psum);

`ifdef BITBLADE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;
    logic           ovf;
    logic           sat_acc_q, sat_acc_d;
    logic           sat_q, sat_d;
    logic           sat_now;

    assign wide    = {acc_q[ACC_W-1], acc_q} + {acc_ext[ACC_W-1], acc_ext};
    assign ovf     = wide[ACC_W] ^ wide[ACC_W-1];
    assign acc_sum = ovf ? (wide[ACC_W] ? ACC_MIN : ACC_MAX)
                         : wide[ACC_W-1:0];
    assign sat_now = sat_acc_q | ovf;
    assign acc_sat = sat_q;
`else
    assign acc_sum = acc_q + acc_ext;
`endif

    always_comb begin
        s1_d  = s1_q;
        acc_d = acc_q;
        res_d = res_q;
        ov_d  = ov_q;
`ifdef BITBLADE_ACC_SAT_EN
        sat_acc_d = sat_acc_q;
        sat_d     = sat_q;
`endif
        if (ov_q & out_ready) ov_d = 1'b0;
        if (adv) begin
            if (s1_q.last) begin
                res_d = acc_sum;
                ov_d  = 1'b1;
                acc_d = '0;
`ifdef BITBLADE_ACC_SAT_EN
                sat_d     = sat_now;
                sat_acc_d = 1'b0;
`endif
            end else begin
                acc_d = acc_sum;
`ifdef BITBLADE_ACC_SAT_EN
                sat_acc_d = sat_now;
`endif
            end
        end
        if (in_ready) begin
            s1_d.valid = in_valid;
            s1_d.last  = in_valid & in_last;
            if (in_valid) s1_d.psum = psum_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            acc_q <= '0;
            res_q <= '0;
            ov_q  <= 1'b0;
`ifdef BITBLADE_ACC_SAT_EN
            sat_acc_q <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            s1_q  <= s1_d;
            acc_q <= acc_d;
            res_q <= res_d;
            ov_q  <= ov_d;
`ifdef BITBLADE_ACC_SAT_EN
            sat_acc_q <= sat_acc_d;
            sat_q     <= sat_d;
`endif
        end
    end

    assign acc_out   = res_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_bitblade_shift_accum.sv
// Directed and randomised checks of bitblade_shift_accum at ACC_W=22.
// Build with BITBLADE_ACC_SAT_EN to exercise the saturating variant.
module tb_bitblade_shift_accum;

    localparam int AW = 22;

    logic                 clk;
    logic                 rst_n;
    logic [95:0]          pp_flat;
    logic [1:0]           prec_x;
    logic [1:0]           prec_y;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic signed [AW-1:0] acc_out;
    logic                 out_valid;
    logic                 out_ready;
`ifdef BITBLADE_ACC_SAT_EN
    logic                 acc_sat;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic signed [AW-1:0] got_q[$];
    longint               exp_q[$];
`ifdef BITBLADE_ACC_SAT_EN
    logic                 got_sat_q[$];
    logic                 exp_sat_q[$];
`endif
    bit tog_en = 0;

    bitblade_shift_accum #(.ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pp_flat   (pp_flat),
        .prec_x    (prec_x),
        .prec_y    (prec_y),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BITBLADE_ACC_SAT_EN
        ,
        .acc_sat   (acc_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(acc_out);
`ifdef BITBLADE_ACC_SAT_EN
            got_sat_q.push_back(acc_sat);
`endif
        end
    end

    function automatic logic [95:0] fill(input logic [5:0] v);
        logic [95:0] r;
        for (int k = 0; k < 16; k++) r[6*k +: 6] = v;
        return r;
    endfunction

    function automatic logic [95:0] one_brick(input int k, input logic [5:0] v);
        logic [95:0] r;
        r = '0;
        r[6*k +: 6] = v;
        return r;
    endfunction

    function automatic longint chunk_weight(input logic [1:0] p, input int c);
        longint w8 [4] = '{1, 4, 16, 64};
        longint w4 [2] = '{1, 4};
        if (p == 2'd0) return 1;
        if (p == 2'd1) return w4[c % 2];
        return w8[c];
    endfunction

    function automatic longint model_psum(input logic [95:0] pp,
                                          input logic [1:0] px,
                                          input logic [1:0] py);
        longint s;
        logic signed [5:0] v;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            v = pp[6*k +: 6];
            s += longint'(v) * chunk_weight(px, k / 4) * chunk_weight(py, k % 4);
        end
        return s;
    endfunction

    function automatic longint wrapv(input longint v);
        logic signed [AW-1:0] t;
        t = v[AW-1:0];
        return longint'(t);
    endfunction

    // Drive one beat from posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [95:0] pp, input logic [1:0] px,
                             input logic [1:0] py, input logic last);
        int n;
        pp_flat  = pp;
        prec_x   = px;
        prec_y   = py;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_beat: in_ready stuck at %0b, need 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_ov(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        pp_flat   = '0;
        prec_x    = 2'd0;
        prec_y    = 2'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %0b need 0", out_valid);
        end
        n_cmp++;
        if (acc_out !== '0) begin
            n_err++;
            $display("FAIL reset_acc_out: got %0d need 0", acc_out);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %0b need 1", in_ready);
        end
        realign();
    endtask

    task automatic test_8x8_latency();
        logic signed [AW-1:0] e;
        e = 22'sd7225;
        send_beat(fill(6'd1), 2'd2, 2'd2, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_t1_out_valid: got %0b need 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || acc_out !== e) begin
            n_err++;
            $display("FAIL lat_t2_8x8: got v=%0b %0d need v=1 %0d",
                     out_valid, acc_out, e);
        end
`ifdef BITBLADE_ACC_SAT_EN
        n_cmp++;
        if (acc_sat !== 1'b0) begin
            n_err++;
            $display("FAIL sat_flag_clear: got %0b need 0", acc_sat);
        end
`endif
        realign();
    endtask

    task automatic test_2x2_multi();
        logic signed [AW-1:0] e;
        bit ok;
        e = -22'sd48;
        for (int b = 0; b < 3; b++)
            send_beat(fill(6'h3F), 2'd0, 2'd0, b == 2);
        wait_ov(ok);
        n_cmp++;
        if (!ok || acc_out !== e) begin
            n_err++;
            $display("FAIL dot_2x2: got v=%0b %0d need v=1 %0d", ok, acc_out, e);
        end
        realign();
        send_beat(one_brick(0, 6'd1), 2'd0, 2'd0, 1'b1);
        wait_ov(ok);
        e = 22'sd1;
        n_cmp++;
        if (!ok || acc_out !== e) begin
            n_err++;
            $display("FAIL acc_cleared: got v=%0b %0d need v=1 %0d", ok, acc_out, e);
        end
        realign();
    endtask

    task automatic test_mixed_prec();
        logic signed [AW-1:0] e;
        bit ok;
        e = 22'sd1280;
        send_beat(one_brick(15, 6'd5), 2'd1, 2'd2, 1'b1);
        wait_ov(ok);
        n_cmp++;
        if (!ok || acc_out !== e) begin
            n_err++;
            $display("FAIL mixed_4x8: got v=%0b %0d need v=1 %0d", ok, acc_out, e);
        end
        realign();
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send_beat(one_brick(0, 6'd1), 2'd0, 2'd0, 1'b1);
        send_beat(one_brick(0, 6'd2), 2'd0, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 22'sd1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b %0d need rdy=0 v=1 1",
                         c, in_ready, out_valid, acc_out);
            end
        end
        realign();
        got_q.delete();
`ifdef BITBLADE_ACC_SAT_EN
        got_sat_q.delete();
`endif
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < 2 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 2) begin
            n_err++;
            $display("FAIL bp_count: got %0d results need 2", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== 22'sd1 || got_q[1] !== 22'sd2) begin
                n_err++;
                $display("FAIL bp_order: got %0d,%0d need 1,2", got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_random();
        longint acc, lim_hi, lim_lo;
        logic   sat;
        logic [95:0] pp;
        logic [1:0]  px, py;
        int nb, n;
        lim_hi = (longint'(1) << (AW - 1)) - 1;
        lim_lo = -(longint'(1) << (AW - 1));
        got_q.delete();
        exp_q.delete();
`ifdef BITBLADE_ACC_SAT_EN
        got_sat_q.delete();
        exp_sat_q.delete();
`endif
        tog_en = 1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int d = 0; d < 1000; d++) begin
            px  = 2'($urandom_range(0, 3));
            py  = 2'($urandom_range(0, 3));
            nb  = $urandom_range(1, 4);
            acc = 0;
            sat = 1'b0;
            for (int b = 0; b < nb; b++) begin
                pp  = {$urandom(), $urandom(), $urandom()};
                acc = acc + model_psum(pp, px, py);
`ifdef BITBLADE_ACC_SAT_EN
                if (acc > lim_hi) begin
                    acc = lim_hi;
                    sat = 1'b1;
                end else if (acc < lim_lo) begin
                    acc = lim_lo;
                    sat = 1'b1;
                end
`else
                acc = wrapv(acc);
`endif
                repeat ($urandom_range(0, 2)) realign();
                send_beat(pp, px, py, b == nb - 1);
            end
            exp_q.push_back(acc);
`ifdef BITBLADE_ACC_SAT_EN
            exp_sat_q.push_back(sat);
`endif
        end
        tog_en = 0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d results need %0d",
                     got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (longint'(got_q[i]) != exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_result[%0d]: got %0d need %0d",
                             i, got_q[i], exp_q[i]);
                end
`ifdef BITBLADE_ACC_SAT_EN
                n_cmp++;
                if (got_sat_q[i] !== exp_sat_q[i]) begin
                    n_err++;
                    $display("FAIL rand_sat[%0d]: got %0b need %0b",
                             i, got_sat_q[i], exp_sat_q[i]);
                end
`endif
            end
        end
        realign();
    endtask

    task automatic test_async_reset();
        int n;
        out_ready = 1'b0;
        send_beat(one_brick(0, 6'd3), 2'd0, 2'd0, 1'b1);
        send_beat(one_brick(0, 6'd5), 2'd0, 2'd0, 1'b0);
        realign();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || acc_out !== 22'sd3) begin
            n_err++;
            $display("FAIL pre_reset_hold: got v=%0b %0d need v=1 3", out_valid, acc_out);
        end
        realign();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || acc_out !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b %0d rdy=%0b need v=0 0 rdy=1",
                     out_valid, acc_out, in_ready);
        end
        realign();
        rst_n = 1'b1;
        got_q.delete();
`ifdef BITBLADE_ACC_SAT_EN
        got_sat_q.delete();
`endif
        out_ready = 1'b1;
        send_beat(one_brick(0, 6'd7), 2'd0, 2'd0, 1'b1);
        n = 0;
        while (got_q.size() < 1 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++;
            $display("FAIL post_reset_count: got %0d results need 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== 22'sd7) begin
                n_err++;
                $display("FAIL post_reset_value: got %0d need 7", got_q[0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [AW-1:0] e;
        bit ok;
`ifdef BITBLADE_ACC_SAT_EN
        e = 22'sd2097151;
`else
        e = -22'sd1954554;
`endif
        for (int b = 0; b < 10; b++)
            send_beat(fill(6'd31), 2'd2, 2'd2, b == 9);
        wait_ov(ok);
        n_cmp++;
        if (!ok || acc_out !== e) begin
            n_err++;
            $display("FAIL overflow_value: got v=%0b %0d need v=1 %0d", ok, acc_out, e);
        end
`ifdef BITBLADE_ACC_SAT_EN
        n_cmp++;
        if (acc_sat !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sat_flag: got %0b need 1", acc_sat);
        end
`endif
        realign();
    endtask

    initial begin
        test_reset();
        test_8x8_latency();
        test_2x2_multi();
        test_mixed_prec();
        test_backpressure();
        test_overflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
